// File: rtl/weight_row_fetcher_pkg.sv
// Shared constants and FSM state type for the weight row fetcher.
package weight_row_fetcher_pkg;

  localparam int unsigned WORD_W       = 100;
  localparam int unsigned WEIGHT_WIDTH = 4;
  localparam int unsigned KERNEL_DIM   = 5;
  localparam int unsigned OUT_W        = 8;
  localparam int unsigned ADDR_W       = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/weight_row_fetcher_unpack.sv
// Combinational unpack of one packed kernel word into a widened row of weights.
// Build option WFETCH_SIGNED_EN selects sign extension instead of zero extension.
module weight_word_unpack
  import weight_row_fetcher_pkg::*;
(
  input  logic [WORD_W-1:0]            word,
  input  logic [2:0]                   row_idx,
  output logic [KERNEL_DIM*OUT_W-1:0]  row
);

  logic [WORD_W-1:0]       shifted;
  logic [WEIGHT_WIDTH-1:0] w;
  int unsigned             idx;

  always_comb begin
    row     = '0;
    shifted = '0;
    w       = '0;
    idx     = 0;
    for (int unsigned c = 0; c < KERNEL_DIM; c++) begin
      idx     = 32'(row_idx) * KERNEL_DIM + c;
      shifted = word >> (idx * WEIGHT_WIDTH);
      w       = shifted[WEIGHT_WIDTH-1:0];
`ifdef WFETCH_SIGNED_EN
      row[c*OUT_W +: OUT_W] = {{(OUT_W-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
`else
      row[c*OUT_W +: OUT_W] = {{(OUT_W-WEIGHT_WIDTH){1'b0}}, w};
`endif
    end
  end

endmodule

// File: rtl/weight_row_fetcher.sv
// Fetches packed 5x5 kernels from the weight SRAM and streams them as row beats.
// Weight widening is signed when WFETCH_SIGNED_EN is defined, unsigned otherwise.
module weight_row_fetcher
  import weight_row_fetcher_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [ADDR_W-1:0]            num_words,
  output logic                         busy,
  output logic                         done,
  output logic                         sram_csb,
  output logic                         sram_wsb,
  output logic [ADDR_W-1:0]            sram_raddr,
  input  logic [WORD_W-1:0]            sram_rdata,
  output logic                         w_valid,
  input  logic                         w_ready,
  output logic [KERNEL_DIM*OUT_W-1:0]  w_row,
  output logic [2:0]                   w_row_idx,
  output logic                         w_last
);

  localparam logic [2:0] ROW_LAST = 3'(KERNEL_DIM - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] popped_q, popped_d;
  logic [WORD_W-1:0] slot0_q, slot0_d;
  logic [WORD_W-1:0] slot1_q, slot1_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [2:0]        row_q, row_d;

  logic       issue, hs, pop, last_word;
  logic [1:0] occ_after;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    row_d      = row_q;

    // An in-flight read already owns a buffer slot, so it counts against capacity.
    issue     = (state_q == FETCH) && (issued_q != num_q) &&
                ((occ_q + {1'b0, inflight_q}) < 2'd2);
    hs        = (occ_q != 2'd0) && w_ready;
    pop       = hs && (row_q == ROW_LAST);
    last_word = ((popped_q + ADDR_W'(1)) == num_q);

    inflight_d = issue;
    if (issue) issued_d = issued_q + ADDR_W'(1);
    if (hs)    row_d    = pop ? 3'd0 : row_q + 3'd1;
    if (pop) begin
      slot0_d  = slot1_q;
      popped_d = popped_q + ADDR_W'(1);
    end

    // Capture lands in the first free slot after this cycle's pop, avoiding a bubble.
    occ_after = occ_q - {1'b0, pop};
    if (inflight_q) begin
      if (occ_after == 2'd0) slot0_d = sram_rdata;
      else                   slot1_d = sram_rdata;
    end
    occ_d = occ_after + {1'b0, inflight_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          num_d    = num_words;
          issued_d = '0;
          popped_d = '0;
          state_d  = (num_words == '0) ? DONE : FETCH;
        end
      end
      FETCH:   if (issue && (issued_d == num_q)) state_d = DRAIN;
      DRAIN:   if (pop && last_word)             state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      row_q      <= row_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign sram_csb   = ~issue;
  assign sram_wsb   = 1'b1;
  assign sram_raddr = base_q + issued_q;
  assign w_valid    = (occ_q != 2'd0);
  assign w_row_idx  = row_q;
  assign w_last     = w_valid && (row_q == ROW_LAST) && last_word;

  weight_word_unpack u_unpack (
    .word    (slot0_q),
    .row_idx (row_q),
    .row     (w_row)
  );

endmodule

// File: tb/tb_weight_row_fetcher.sv
// Directed, table-driven bench for weight_row_fetcher with a behavioural SRAM.
`timescale 1ns/1ps
module tb_weight_row_fetcher;
  import weight_row_fetcher_pkg::*;

  logic         clk = 1'b0;
  logic         rst, start, busy, done, sram_csb, sram_wsb, w_valid, w_ready, w_last;
  logic [14:0]  base_addr, num_words, sram_raddr;
  logic [99:0]  sram_rdata = '0;
  logic [39:0]  w_row;
  logic [2:0]   w_row_idx;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  weight_row_fetcher dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .sram_csb(sram_csb), .sram_wsb(sram_wsb),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .w_valid(w_valid),
    .w_ready(w_ready), .w_row(w_row), .w_row_idx(w_row_idx), .w_last(w_last)
  );

  // Weight j of the word at addr is (j + 3*((addr+11) mod 16)) mod 16; addr 21 gives j mod 16.
  function automatic logic [3:0] ref_w(input logic [14:0] addr, input int unsigned j);
    int unsigned o;
    o = 3 * ((32'(addr) + 11) % 16);
    return 4'((j + o) % 16);
  endfunction

  function automatic logic [99:0] mem_word(input logic [14:0] addr);
    logic [99:0] wd;
    wd = '0;
    for (int unsigned j = 0; j < 25; j++) wd[4*j +: 4] = ref_w(addr, j);
    return wd;
  endfunction

  function automatic logic [7:0] widen(input logic [3:0] w);
`ifdef WFETCH_SIGNED_EN
    return {{4{w[3]}}, w};
`else
    return {4'h0, w};
`endif
  endfunction

  function automatic logic [39:0] ref_row(input logic [14:0] addr, input int unsigned r);
    logic [39:0] rw;
    for (int unsigned c = 0; c < 5; c++) rw[8*c +: 8] = widen(ref_w(addr, 5*r + c));
    return rw;
  endfunction

  // Hand tables hold zero-extended lanes; re-widen each lane for the signed build.
  function automatic logic [39:0] hand_row(input logic [39:0] u);
    logic [39:0] rw;
    for (int unsigned c = 0; c < 5; c++) rw[8*c +: 8] = widen(u[8*c +: 4]);
    return rw;
  endfunction

  always @(posedge clk) if (!sram_csb) sram_rdata <= mem_word(sram_raddr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [14:0] base;
    logic [14:0] num;
    int          stall;
    bit          intrude;
    bit          nogap;
    bit          pre_rst;
    logic [39:0] row0_u;
    logic [39:0] row1_u;
  } job_t;

  task automatic run_job(input job_t j);
    int          reads = 0, beats = 0, cyc = 0, first_valid = -1, last_hs = -1, done_cyc = -1;
    bit          prev_stalled = 0;
    logic [39:0] held_row = '0;
    logic [2:0]  held_idx = '0;
    logic [14:0] exp_addr;
    int          r;

    if (j.pre_rst) begin
      @(negedge clk); base_addr = 15'd300; num_words = 15'd4; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("rst_first_issue", 64'(sram_csb), 64'(0));
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("rst_w_valid", 64'(w_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_csb", 64'(sram_csb), 64'(1));
      chk("rst_raddr", 64'(sram_raddr), 64'(0));
      rst = 1'b0;
    end

    @(negedge clk); base_addr = j.base; num_words = j.num; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));

    while (done_cyc < 0 && cyc < 600) begin
      if (j.intrude && cyc == 3) begin
        base_addr = 15'(j.base + 100); num_words = 15'(j.num + 1); start = 1'b1;
      end else start = 1'b0;
      chk("wsb", 64'(sram_wsb), 64'(1));
      if (!sram_csb) begin
        chk("raddr", 64'(sram_raddr), 64'(15'(j.base + 15'(reads))));
        reads++;
      end
      if (w_valid && first_valid < 0) first_valid = cyc;
      w_ready = !(first_valid >= 0 && cyc < first_valid + j.stall);
      if (j.stall > 0 && first_valid >= 0 && cyc == first_valid + j.stall - 1)
        chk("reads_at_stall", 64'(reads), 64'(2));
      if (prev_stalled) begin
        chk("hold_valid", 64'(w_valid), 64'(1));
        chk("hold_row", 64'(w_row), 64'(held_row));
        chk("hold_idx", 64'(w_row_idx), 64'(held_idx));
      end
      if (j.nogap && beats > 0 && beats < 5 * int'(j.num))
        chk("no_gap", 64'(w_valid), 64'(1));
      if (w_valid && w_ready) begin
        exp_addr = 15'(j.base + 15'(beats / 5));
        r = beats % 5;
        chk("beat_row", 64'(w_row), 64'(ref_row(exp_addr, r)));
        chk("beat_idx", 64'(w_row_idx), 64'(r));
        chk("beat_last", 64'(w_last), 64'(beats == 5 * int'(j.num) - 1));
        if (beats == 0) chk("hand_row0", 64'(w_row), 64'(hand_row(j.row0_u)));
        if (beats == 1) chk("hand_row1", 64'(w_row), 64'(hand_row(j.row1_u)));
        if (beats == 5 * int'(j.num) - 1) last_hs = cyc;
        beats++;
      end
      prev_stalled = w_valid && !w_ready;
      held_row = w_row;
      held_idx = w_row_idx;
      if (done) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    w_ready = 1'b1;

    chk("done_seen", 64'(done_cyc >= 0), 64'(1));
    chk("done_latency", 64'(done_cyc), 64'(j.num == 0 ? 0 : last_hs + 1));
    chk("read_count", 64'(reads), 64'(j.num));
    chk("beat_count", 64'(beats), 64'(5 * int'(j.num)));
    repeat (3) begin
      @(negedge clk);
      chk("idle_done", 64'(done), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_valid", 64'(w_valid), 64'(0));
      chk("idle_csb", 64'(sram_csb), 64'(1));
    end
  endtask

  job_t jobs[6];

  initial begin
    jobs[0] = '{15'd21,    15'd1, 0,  1'b0, 1'b1, 1'b0, 40'h04_03_02_01_00, 40'h09_08_07_06_05};
    jobs[1] = '{15'd1100,  15'd4, 0,  1'b0, 1'b1, 1'b0, 40'h09_08_07_06_05, 40'h0E_0D_0C_0B_0A};
    jobs[2] = '{15'd40,    15'd3, 30, 1'b0, 1'b0, 1'b0, 40'h0D_0C_0B_0A_09, 40'h02_01_00_0F_0E};
    jobs[3] = '{15'd0,     15'd0, 0,  1'b0, 1'b0, 1'b0, 40'h0,              40'h0};
    jobs[4] = '{15'd500,   15'd2, 0,  1'b0, 1'b1, 1'b1, 40'h01_00_0F_0E_0D, 40'h06_05_04_03_02};
    jobs[5] = '{15'd7,     15'd2, 0,  1'b1, 1'b1, 1'b0, 40'h0A_09_08_07_06, 40'h0F_0E_0D_0C_0B};

    rst = 1'b1; start = 1'b0; w_ready = 1'b1; base_addr = '0; num_words = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_csb", 64'(sram_csb), 64'(1));
    chk("reset_raddr", 64'(sram_raddr), 64'(0));
    chk("reset_valid", 64'(w_valid), 64'(0));
    chk("reset_row", 64'(w_row), 64'(0));
    chk("reset_idx", 64'(w_row_idx), 64'(0));
    chk("reset_last", 64'(w_last), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Address wrap past the top of the 15-bit space.
    run_job('{15'd32766, 15'd3, 0, 1'b0, 1'b1, 1'b0, 40'h0F_0E_0D_0C_0B, 40'h04_03_02_01_00});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
